// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
//   fetch_state_e : fetch controller states (BOOT, RUN, FAULT)
//   B_OPCODE      : primary opcode of the unconditional B instruction
//   INSTR_BYTES   : bytes per instruction word
//   NOP_INSTR     : value held in IF/ID when it carries no instruction
//   b_offset()    : byte offset encoded in a B instruction's imm26 field
//   is_b()        : true when an instruction word is an unconditional B
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } fetch_state_e;

    localparam logic [5:0]  B_OPCODE       = 6'b000101;
    localparam int          INSTR_BYTES    = 4;
    localparam logic [63:0] INSTR_BYTES_64 = 64'd4;
    localparam logic [31:0] NOP_INSTR      = 32'h0000_0000;

    // imm26 counts words; sign-extend and scale to bytes.
    function automatic logic [63:0] b_offset(input logic [25:0] imm26);
        return {{36{imm26[25]}}, imm26, 2'b00};
    endfunction

    function automatic logic is_b(input logic [31:0] instr);
        return (instr[31:26] == B_OPCODE);
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction ROM bus between the fetch stage and the ROM.
//   imem_address     : byte address driven by fetch (the PC register)
//   imem_instruction : combinational ROM read data for imem_address
// Modports:
//   master : fetch side (drives the address)
//   slave  : ROM side (returns the instruction word)
interface instr_fetch_if;

    logic [63:0] imem_address;
    logic [31:0] imem_instruction;

    modport master (
        output imem_address,
        input  imem_instruction
    );

    modport slave (
        input  imem_address,
        output imem_instruction
    );

endinterface

// File: rtl/fetch_addr_check.sv
// Combinational legality check for a fetch byte address.
// An address is legal when it is word aligned and the whole word lies inside
// the ROM, i.e. address + 3 < IMEM_SIZE, compared unsigned in 64 bits.
//   address : byte address under test
//   legal   : 1 when the address may be fetched
module fetch_addr_check #(
    parameter int IMEM_SIZE = 1024
) (
    input  logic [63:0] address,
    output logic        legal
);

    localparam logic [63:0] SIZE_W = 64'(IMEM_SIZE);

    logic [63:0] last_byte_s;

    // An aligned address never carries out of 64 bits when adding 3.
    assign last_byte_s = address + 64'd3;
    assign legal       = (address[1:0] == 2'b00) && (last_byte_s < SIZE_W);

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage sitting directly upstream of the instruction ROM.
// Owns the 64-bit PC, drives the ROM address through the instr_fetch_if
// master modport and captures the returned word into the IF/ID register.
// Redirect beats stall beats sequential advance. An illegal next address
// parks the stage in FAULT until a legal redirect or reset.
//
// Optional feature (macro STATIC_B_REDIRECT_EN): unconditional B
// instructions are followed at fetch time and flagged on id_pred_taken.
//
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   imem              : ROM bus (imem_address out, imem_instruction in)
//   stall             : hold PC and IF/ID
//   redirect_valid    : later stage resolved a taken branch
//   redirect_target   : byte target of that branch
//   id_valid          : IF/ID holds a real instruction
//   id_instruction    : latched instruction
//   id_pc             : PC of the latched instruction
//   id_pc_plus4       : id_pc + 4 (BL link value)
//   id_pred_taken     : fetch already redirected on this instruction
//   fault             : fetch halted on an illegal address
//   fault_pc          : offending address
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC  = 64'd0,
    parameter int          IMEM_SIZE = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    instr_fetch_if.master        imem,
    input  logic                 stall,
    input  logic                 redirect_valid,
    input  logic [63:0]          redirect_target,
    output logic                 id_valid,
    output logic [31:0]          id_instruction,
    output logic [63:0]          id_pc,
    output logic [63:0]          id_pc_plus4,
    output logic                 id_pred_taken,
    output logic                 fault,
    output logic [63:0]          fault_pc
);

    fetch_state_e state_q, state_d;
    logic [63:0]  pc_q, pc_d;
    logic         id_valid_q, id_valid_d;
    logic [31:0]  id_instr_q, id_instr_d;
    logic [63:0]  id_pc_q, id_pc_d;
    logic [63:0]  id_pc4_q, id_pc4_d;
    logic         fault_q, fault_d;
    logic [63:0]  fault_pc_q, fault_pc_d;

    logic [63:0]  pc_plus4_s;
    logic         pc_plus4_legal_s;
    logic         redirect_legal_s;
    logic [63:0]  seq_target_s;
    logic         seq_legal_s;
    logic         seq_pred_s;

    assign pc_plus4_s = pc_q + INSTR_BYTES_64;

    fetch_addr_check #(.IMEM_SIZE(IMEM_SIZE)) u_chk_plus4 (
        .address (pc_plus4_s),
        .legal   (pc_plus4_legal_s)
    );

    fetch_addr_check #(.IMEM_SIZE(IMEM_SIZE)) u_chk_redirect (
        .address (redirect_target),
        .legal   (redirect_legal_s)
    );

`ifdef STATIC_B_REDIRECT_EN
    logic        id_pred_q, id_pred_d;
    logic        take_b_s;
    logic [63:0] b_target_s;
    logic        b_legal_s;

    assign take_b_s   = is_b(imem.imem_instruction);
    assign b_target_s = pc_q + b_offset(imem.imem_instruction[25:0]);

    fetch_addr_check #(.IMEM_SIZE(IMEM_SIZE)) u_chk_btarget (
        .address (b_target_s),
        .legal   (b_legal_s)
    );

    // A B instruction replaces the sequential successor with its own target.
    assign seq_target_s  = take_b_s ? b_target_s : pc_plus4_s;
    assign seq_legal_s   = take_b_s ? b_legal_s  : pc_plus4_legal_s;
    assign seq_pred_s    = take_b_s;
    assign id_pred_taken = id_pred_q;
`else
    assign seq_target_s  = pc_plus4_s;
    assign seq_legal_s   = pc_plus4_legal_s;
    assign seq_pred_s    = 1'b0;
    assign id_pred_taken = 1'b0;
`endif

    // Next-state and next-register logic of the fetch controller.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        id_valid_d = id_valid_q;
        id_instr_d = id_instr_q;
        id_pc_d    = id_pc_q;
        id_pc4_d   = id_pc4_q;
        fault_d    = fault_q;
        fault_pc_d = fault_pc_q;
`ifdef STATIC_B_REDIRECT_EN
        id_pred_d  = id_pred_q;
`endif
        case (state_q)
            BOOT: begin
                // ROM address settles for one cycle; inputs are ignored.
                state_d = RUN;
            end
            RUN: begin
                if (redirect_valid) begin
                    // Squash whatever was fetched this cycle.
                    id_valid_d = 1'b0;
                    if (redirect_legal_s) begin
                        pc_d = redirect_target;
                    end else begin
                        state_d    = FAULT;
                        fault_d    = 1'b1;
                        fault_pc_d = redirect_target;
                    end
                end else if (stall) begin
                    id_valid_d = id_valid_q;
                end else begin
                    id_valid_d = 1'b1;
                    id_instr_d = imem.imem_instruction;
                    id_pc_d    = pc_q;
                    id_pc4_d   = pc_plus4_s;
`ifdef STATIC_B_REDIRECT_EN
                    id_pred_d  = seq_pred_s;
`endif
                    // The current word is delivered even if its successor faults.
                    if (seq_legal_s) begin
                        pc_d = seq_target_s;
                    end else begin
                        state_d    = FAULT;
                        fault_d    = 1'b1;
                        fault_pc_d = seq_target_s;
                    end
                end
            end
            FAULT: begin
                if (!stall) begin
                    id_valid_d = 1'b0;
                end else begin
                    id_valid_d = id_valid_q;
                end
                if (redirect_valid) begin
                    if (redirect_legal_s) begin
                        pc_d       = redirect_target;
                        fault_d    = 1'b0;
                        state_d    = RUN;
                        id_valid_d = 1'b0;
                    end else begin
                        fault_pc_d = redirect_target;
                    end
                end else begin
                    state_d = FAULT;
                end
            end
            default: begin
                state_d    = BOOT;
                id_valid_d = 1'b0;
            end
        endcase
    end

    // Fetch state, PC and IF/ID pipeline registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            id_valid_q <= 1'b0;
            id_instr_q <= NOP_INSTR;
            id_pc_q    <= 64'd0;
            id_pc4_q   <= 64'd0;
            fault_q    <= 1'b0;
            fault_pc_q <= 64'd0;
`ifdef STATIC_B_REDIRECT_EN
            id_pred_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            id_valid_q <= id_valid_d;
            id_instr_q <= id_instr_d;
            id_pc_q    <= id_pc_d;
            id_pc4_q   <= id_pc4_d;
            fault_q    <= fault_d;
            fault_pc_q <= fault_pc_d;
`ifdef STATIC_B_REDIRECT_EN
            id_pred_q  <= id_pred_d;
`endif
        end
    end

    assign imem.imem_address = pc_q;
    assign id_valid          = id_valid_q;
    assign id_instruction    = id_instr_q;
    assign id_pc             = id_pc_q;
    assign id_pc_plus4       = id_pc4_q;
    assign fault             = fault_q;
    assign fault_pc          = fault_pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed testbench for instr_fetch with a 1 KiB ROM model.
module tb_instr_fetch;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [63:0] redirect_target;
    logic        id_valid;
    logic [31:0] id_instruction;
    logic [63:0] id_pc;
    logic [63:0] id_pc_plus4;
    logic        id_pred_taken;
    logic        fault;
    logic [63:0] fault_pc;

    int vectors;
    int miscompares;

    logic [31:0] rom [256];

    instr_fetch_if bus ();

    assign bus.imem_instruction = rom[bus.imem_address[9:2]];

    instr_fetch #(.RESET_PC(64'd0), .IMEM_SIZE(1024)) dut (
        .clk             (clk),
        .reset           (reset),
        .imem            (bus.master),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .id_valid        (id_valid),
        .id_instruction  (id_instruction),
        .id_pc           (id_pc),
        .id_pc_plus4     (id_pc_plus4),
        .id_pred_taken   (id_pred_taken),
        .fault           (fault),
        .fault_pc        (fault_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input int idx);
`ifdef STATIC_B_REDIRECT_EN
        if (idx == 4) return 32'h1400_0004;
`endif
        return 32'hA000_0000 | 32'(idx);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_state();
        chk("rst_id_valid", 64'(id_valid), 64'd0);
        chk("rst_id_instr", 64'(id_instruction), 64'd0);
        chk("rst_id_pc", id_pc, 64'd0);
        chk("rst_id_pc4", id_pc_plus4, 64'd0);
        chk("rst_pred", 64'(id_pred_taken), 64'd0);
        chk("rst_fault", 64'(fault), 64'd0);
        chk("rst_fault_pc", fault_pc, 64'd0);
        chk("rst_addr", bus.imem_address, 64'd0);
    endtask

    initial begin
        logic        b_on;
        vectors         = 0;
        miscompares     = 0;
`ifdef STATIC_B_REDIRECT_EN
        b_on = 1'b1;
`else
        b_on = 1'b0;
`endif
        for (int i = 0; i < 256; i++) rom[i] = rom_word(i);
        reset           = 1'b1;
        stall           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 64'd0;

        // Reset values
        tick();
        chk_reset_state();

        // Release: BOOT cycle, then sequential fetch
        reset = 1'b0;
        tick();
        chk("boot_valid", 64'(id_valid), 64'd0);
        chk("boot_addr", bus.imem_address, 64'd0);
        tick();
        chk("seq0_valid", 64'(id_valid), 64'd1);
        chk("seq0_pc", id_pc, 64'd0);
        chk("seq0_instr", 64'(id_instruction), 64'(rom_word(0)));
        chk("seq0_pc4", id_pc_plus4, 64'd4);
        chk("seq0_addr", bus.imem_address, 64'd4);
        tick();
        chk("seq1_pc", id_pc, 64'd4);
        chk("seq1_instr", 64'(id_instruction), 64'(rom_word(1)));
        chk("seq1_addr", bus.imem_address, 64'd8);

        // Stall three cycles at pc=8
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_addr", bus.imem_address, 64'd8);
            chk("stall_id_pc", id_pc, 64'd4);
            chk("stall_valid", 64'(id_valid), 64'd1);
        end
        stall = 1'b0;
        tick();
        chk("unstall_pc", id_pc, 64'd8);
        chk("unstall_instr", 64'(id_instruction), 64'(rom_word(2)));
        chk("unstall_addr", bus.imem_address, 64'd12);

        // Redirect to 0x40 while stalled
        stall           = 1'b1;
        redirect_valid  = 1'b1;
        redirect_target = 64'h40;
        tick();
        chk("redir_valid", 64'(id_valid), 64'd0);
        chk("redir_addr", bus.imem_address, 64'h40);
        chk("redir_id_pc_hold", id_pc, 64'd8);
        stall          = 1'b0;
        redirect_valid = 1'b0;
        tick();
        chk("redir_id_pc", id_pc, 64'h40);
        chk("redir_id_valid", 64'(id_valid), 64'd1);
        chk("redir_instr", 64'(id_instruction), 64'(rom_word(16)));
        chk("redir_pc4", id_pc_plus4, 64'h44);

        // Misaligned redirect target
        redirect_valid  = 1'b1;
        redirect_target = 64'h42;
        tick();
        chk("mis_fault", 64'(fault), 64'd1);
        chk("mis_fault_pc", fault_pc, 64'h42);
        chk("mis_valid", 64'(id_valid), 64'd0);
        chk("mis_addr", bus.imem_address, 64'h44);

        // Out-of-range redirect while already faulted
        redirect_target = 64'h400;
        tick();
        chk("oor_fault", 64'(fault), 64'd1);
        chk("oor_fault_pc", fault_pc, 64'h400);
        chk("oor_addr", bus.imem_address, 64'h44);

        // Legal redirect recovers
        redirect_target = 64'h10;
        tick();
        chk("rec_fault", 64'(fault), 64'd0);
        chk("rec_addr", bus.imem_address, 64'h10);
        chk("rec_valid", 64'(id_valid), 64'd0);
        redirect_valid = 1'b0;
        tick();
        chk("rec_id_pc", id_pc, 64'h10);
        chk("rec_id_valid", 64'(id_valid), 64'd1);

        // Sequential fetch running off the top of the ROM
        redirect_valid  = 1'b1;
        redirect_target = 64'h3F0;
        tick();
        redirect_valid = 1'b0;
        tick();
        chk("top0_pc", id_pc, 64'h3F0);
        tick();
        chk("top1_pc", id_pc, 64'h3F4);
        tick();
        chk("top2_pc", id_pc, 64'h3F8);
        chk("top2_addr", bus.imem_address, 64'h3FC);
        tick();
        chk("top3_pc", id_pc, 64'h3FC);
        chk("top3_valid", 64'(id_valid), 64'd1);
        chk("top3_instr", 64'(id_instruction), 64'(rom_word(255)));
        chk("top3_pc4", id_pc_plus4, 64'h400);
        chk("top3_fault", 64'(fault), 64'd1);
        chk("top3_fault_pc", fault_pc, 64'h400);
        chk("top3_addr", bus.imem_address, 64'h3FC);
        tick();
        chk("top4_valid", 64'(id_valid), 64'd0);
        chk("top4_fault", 64'(fault), 64'd1);
        chk("top4_addr", bus.imem_address, 64'h3FC);

        // Reset while faulted, stalled and redirecting
        reset           = 1'b1;
        stall           = 1'b1;
        redirect_valid  = 1'b1;
        redirect_target = 64'h80;
        tick();
        chk_reset_state();
        reset          = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        tick();
        chk("rb_boot_valid", 64'(id_valid), 64'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rb_seq_pc", id_pc, 64'(4 * i));
        end
        chk("rb_addr", bus.imem_address, 64'h10);

        // Word at 0x10 is an unconditional B with imm26=+4 when the feature is on
        tick();
        chk("b_id_pc", id_pc, 64'h10);
        chk("b_instr", 64'(id_instruction), 64'(rom_word(4)));
        chk("b_pred", 64'(id_pred_taken), b_on ? 64'd1 : 64'd0);
        chk("b_addr", bus.imem_address, b_on ? 64'h20 : 64'h14);
        tick();
        chk("b_next_valid", 64'(id_valid), 64'd1);
        chk("b_next_pc", id_pc, b_on ? 64'h20 : 64'h14);
        chk("b_next_pred", 64'(id_pred_taken), 64'd0);

        // Reset mid-sequence
        reset = 1'b1;
        tick();
        chk_reset_state();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
